// File: rtl/seq_div16.sv
// Restoring radix-2 unsigned divider: one trial subtraction per BUSY cycle,
// valid/ready on both sides, divide-by-zero short-circuits straight to DONE.
module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // work_q starts as the dividend; quotient bits fill in from the LSB as
    // dividend bits leave from the MSB, so after WIDTH shifts it is the quotient.
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] prem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] prem_d;

    assign accept    = in_valid && in_ready;
    assign last_iter = (state_q == S_BUSY) && (cnt_q == CW'(1));

    // Stored remainder is always < divisor, so WIDTH bits suffice; the shift
    // widens it to the WIDTH+1-bit trial value.
    assign shifted = {prem_q, work_q[WIDTH-1]};
    assign take    = (shifted >= {1'b0, dvs_q});
    assign prem_d  = take ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (divisor == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q      <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (accept) begin
                if (divisor != '0) begin
                    work_q <= dividend;
                    dvs_q  <= divisor;
                    prem_q <= '0;
                    cnt_q  <= CW'(WIDTH);
                end else begin
                    quotient_q  <= '1;
                    remainder_q <= dividend;
                    dbz_q       <= 1'b1;
                end
            end
        end else if (state_q == S_BUSY) begin
            work_q <= {work_q[WIDTH-2:0], take};
            prem_q <= prem_d;
            cnt_q  <= cnt_q - CW'(1);
            if (last_iter) begin
                quotient_q  <= {work_q[WIDTH-2:0], take};
                remainder_q <= prem_d;
                dbz_q       <= 1'b0;
            end
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: driver pushes expected results computed with
// plain / and %, a negedge monitor pops and compares each delivered result.
module tb_seq_div16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_div16 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   n_results = 0;
    int   n_aborted = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic. A real divide finishes W edges after the
    // accepting edge; a divide-by-zero is visible in the first cycle after
    // accept (0 extra edges).
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.acc = acc;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.z   = 1'b1;
            e.lat = 0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.z   = 1'b0;
            e.lat = W;
        end
        return e;
    endfunction

    // Monitor
    bit           seen = 1'b0;
    logic [W-1:0] hq, hr;
    logic         hz;
    exp_t         me;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                n_results++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got q=%0h r=%0h, expected no result", quotient, remainder);
                end else begin
                    me = sb.pop_front();
                    $display("result %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d",
                             me.a, me.b, quotient, remainder, div_by_zero, cyc - me.acc - 1);
                    check("quotient", quotient, me.q);
                    check("remainder", remainder, me.r);
                    check("div_by_zero", div_by_zero, me.z);
                    check("latency", cyc - me.acc - 1, me.lat);
                    if (me.b != 0) begin
                        check("identity", 64'(quotient) * 64'(me.b) + 64'(remainder), 64'(me.a));
                        check("rem_lt_div", (remainder < me.b), 1);
                    end
                end
                seen = 1'b1;
                hq = quotient;
                hr = remainder;
                hz = div_by_zero;
            end else begin
                check("hold_quotient", quotient, hq);
                check("hold_remainder", remainder, hr);
                check("hold_dbz", div_by_zero, hz);
            end
            if (out_ready) seen = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(a, b, cyc));
                n_issued++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected accept of %0d/%0d", a, b);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] ra, rb, mask;
    initial begin
        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        issue(16'd100, 16'd7);
        drain();

        // Operands offered while busy must be ignored
        issue(16'd3, 16'd10);
        in_valid = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        issue(16'hFFFF, 16'd1);
        issue(16'd5, 16'd0);
        drain();

        // Back-pressure in DONE
        out_ready = 1'b0;
        issue(16'd100, 16'd7);
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid_held", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        check("idle_hold_quotient", quotient, 14);
        check("idle_hold_remainder", remainder, 2);

        // Reset in the middle of BUSY
        issue(16'd100, 16'd7);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        n_aborted++;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        issue(16'd40, 16'd6);
        drain();

        // Random back-to-back with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = 16'd1;
                default: begin
                    mask = W'((32'd1 << $urandom_range(1, W)) - 1);
                    rb = W'($urandom) & mask;
                end
            endcase
            issue(ra, rb);
        end
        drain();
        rand_ready = 1'b0;

        check("result_count", n_results, n_issued - n_aborted);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div16.md
SEQ_DIV16 -- requirements
Module: seq_div16

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal 4..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  WIDTH  unsigned dividend.
REQ-007 divisor  input  WIDTH  unsigned divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  WIDTH  unsigned quotient.
REQ-011 remainder  output  WIDTH  unsigned remainder.
REQ-012 div_by_zero  output  1  result produced with divisor==0.

Function
REQ-013 The block SHALL be a restoring radix-2 divider: one trial subtraction (WIDTH+1-bit partial remainder minus zero-extended divisor) per BUSY cycle.
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on in_valid&&in_ready with divisor!=0, the block SHALL latch both operands, clear the partial remainder, load the iteration counter with WIDTH, and go to BUSY.
REQ-016 IDLE: on in_valid&&in_ready with divisor==0, the block SHALL go directly to DONE with quotient=all-ones, remainder=dividend, div_by_zero=1.
REQ-017 BUSY, each cycle: shift partial remainder left, inserting the current dividend MSB; if the result >= divisor, subtract and shift 1 into the quotient, else keep it and shift 0 in; decrement the counter.
REQ-018 BUSY SHALL last exactly WIDTH cycles; out_valid SHALL rise exactly WIDTH cycles after the accepting edge (1 cycle for divide-by-zero).
REQ-019 DONE: quotient, remainder, and div_by_zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 DONE: on out_ready=1 the block SHALL return to IDLE on that edge; in_ready SHALL be 1 the next cycle, with no same-cycle accept.
REQ-021 in_valid during BUSY/DONE SHALL be ignored; operands are not sampled outside IDLE.
REQ-022 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for divisor!=0.
REQ-023 div_by_zero SHALL be 0 for every result with divisor!=0.
REQ-024 quotient/remainder SHALL hold the last result in IDLE until the next completion overwrites them.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no result delivered.
REQ-027 The first accepting edge after rst_n deassertion SHALL be treated as a normal accept.

Verification
REQ-028 dividend=100, divisor=7, out_ready=1 -> out_valid 16 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-029 dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-030 dividend=5, divisor=0 -> out_valid 1 cycle after accept, quotient=16'hFFFF, remainder=5, div_by_zero=1.
REQ-031 100/7 with out_ready=0 for 3 cycles in DONE -> outputs stable 3 cycles, in_ready=0; IDLE after out_ready=1, in_ready=1 next cycle.
REQ-032 rst_n pulsed low at BUSY cycle 8 -> out_valid=0, outputs zero, no result; a new 40/6 request completes with quotient=6, remainder=4.
REQ-033 Random back-to-back requests (1000, incl. divisor 0 and 1) checked against the REQ-022 identity and the REQ-018 latency.
